// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: pipeline port A and secondary port B share one
// single-ported SRAM. A normally wins; a starved B is given one forced turn.
module dmem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rstb,

    input  logic        a_req,
    input  logic        a_we,
    input  logic [31:0] a_addr,
    input  logic [31:0] a_wdata,
    output logic        a_gnt,
    output logic        a_stall,
    output logic        a_rvalid,
    output logic [31:0] a_rdata,

    input  logic        b_req,
    input  logic        b_we,
    input  logic [31:0] b_addr,
    input  logic [31:0] b_wdata,
    output logic        b_gnt,
    output logic        b_rvalid,
    output logic [31:0] b_rdata,

    output logic        mem_oe,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    input  logic [31:0] mem_dout
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic {
        A_PRI = 1'b0,
        B_PRI = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [3:0]  r_starve_cnt;
    logic [3:0]  w_starve_next;
    logic        w_a_gnt;
    logic        w_b_gnt;

    logic        r_a_rvalid;
    logic [31:0] r_a_rdata;
    logic        r_b_rvalid;
    logic [31:0] r_b_rdata;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state      <= A_PRI;
            r_starve_cnt <= '0;
        end else begin
            r_state      <= w_state_next;
            r_starve_cnt <= w_starve_next;
        end
    end

    // Grants are suppressed while reset is held so the SRAM sees no access.
    always_comb begin
        w_a_gnt       = 1'b0;
        w_b_gnt       = 1'b0;
        w_starve_next = '0;
        w_state_next  = r_state;

        if (rstb) begin
            if (r_state == B_PRI) begin
                if (b_req)      w_b_gnt = 1'b1;
                else if (a_req) w_a_gnt = 1'b1;
            end else begin
                if (a_req)      w_a_gnt = 1'b1;
                else if (b_req) w_b_gnt = 1'b1;
            end
        end

        if (b_req && !w_b_gnt) begin
            w_starve_next = (r_starve_cnt >= LIMIT) ? LIMIT : r_starve_cnt + 4'd1;
        end

        // B_PRI lasts exactly one cycle, whether B used it or gave it up.
        case (r_state)
            A_PRI:   if (w_starve_next == LIMIT) w_state_next = B_PRI;
            B_PRI:   w_state_next = A_PRI;
            default: w_state_next = A_PRI;
        endcase
    end

    always_comb begin
        mem_oe   = 1'b0;
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_din  = '0;
        if (w_a_gnt) begin
            mem_oe   = ~a_we;
            mem_we   = a_we;
            mem_addr = a_addr;
            mem_din  = a_wdata;
        end else if (w_b_gnt) begin
            mem_oe   = ~b_we;
            mem_we   = b_we;
            mem_addr = b_addr;
            mem_din  = b_wdata;
        end
    end

    // Read data is captured at the granting edge and held until that port's next read.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_a_rvalid <= 1'b0;
            r_a_rdata  <= '0;
            r_b_rvalid <= 1'b0;
            r_b_rdata  <= '0;
        end else begin
            r_a_rvalid <= w_a_gnt & ~a_we;
            r_b_rvalid <= w_b_gnt & ~b_we;
            if (w_a_gnt && !a_we) r_a_rdata <= mem_dout;
            if (w_b_gnt && !b_we) r_b_rdata <= mem_dout;
        end
    end

    assign a_gnt    = w_a_gnt;
    assign b_gnt    = w_b_gnt;
    assign a_stall  = a_req & ~w_a_gnt;
    assign a_rvalid = r_a_rvalid;
    assign a_rdata  = r_a_rdata;
    assign b_rvalid = r_b_rvalid;
    assign b_rdata  = r_b_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a cycle-by-cycle vector table plus
// hand-written back-to-back and reset-during-read sequences.
module tb_dmem_arbiter;

    localparam bit T = 1'b1;
    localparam bit F = 1'b0;

    logic        clk;
    logic        rstb;
    logic        a_req, a_we;
    logic [31:0] a_addr, a_wdata;
    logic        a_gnt, a_stall, a_rvalid;
    logic [31:0] a_rdata;
    logic        b_req, b_we;
    logic [31:0] b_addr, b_wdata;
    logic        b_gnt, b_rvalid;
    logic [31:0] b_rdata;
    logic        mem_oe, mem_we;
    logic [31:0] mem_addr, mem_din, mem_dout;

    int n_vec  = 0;
    int n_miss = 0;

    dmem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .rstb(rstb),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_stall(a_stall), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .mem_oe(mem_oe), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          ar, aw;
        logic [31:0] aa, ad;
        bit          br, bw;
        logic [31:0] ba, bd;
        logic [31:0] md;
        bit          e_ag, e_bg, e_st, e_oe, e_we;
        logic [31:0] e_addr, e_din;
        bit          e_arv;
        logic [31:0] e_ard;
        bit          e_brv;
        logic [31:0] e_brd;
    } vec_t;

    vec_t vecs[26];

    function automatic vec_t mk(bit ar, bit aw, logic [31:0] aa, logic [31:0] ad,
                                bit br, bit bw, logic [31:0] ba, logic [31:0] bd,
                                logic [31:0] md,
                                bit ag, bit bg, bit st, bit oe, bit we,
                                logic [31:0] addr, logic [31:0] din,
                                bit arv, logic [31:0] ard, bit brv, logic [31:0] brd);
        vec_t v;
        v.ar = ar; v.aw = aw; v.aa = aa; v.ad = ad;
        v.br = br; v.bw = bw; v.ba = ba; v.bd = bd; v.md = md;
        v.e_ag = ag; v.e_bg = bg; v.e_st = st; v.e_oe = oe; v.e_we = we;
        v.e_addr = addr; v.e_din = din;
        v.e_arv = arv; v.e_ard = ard; v.e_brv = brv; v.e_brd = brd;
        return v;
    endfunction

    task automatic drive(bit ar, bit aw, logic [31:0] aa, logic [31:0] ad,
                         bit br, bit bw, logic [31:0] ba, logic [31:0] bd,
                         logic [31:0] md);
        a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
        b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
        mem_dout = md;
    endtask

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end else begin
            $display("ok   %s = %h", nm, got);
        end
    endtask

    task automatic apply(int idx);
        logic [134:0] got, exp;
        vec_t v;
        v = vecs[idx];
        @(negedge clk);
        drive(v.ar, v.aw, v.aa, v.ad, v.br, v.bw, v.ba, v.bd, v.md);
        #1;
        got = {a_gnt, b_gnt, a_stall, mem_oe, mem_we, mem_addr, mem_din,
               a_rvalid, a_rdata, b_rvalid, b_rdata};
        exp = {v.e_ag, v.e_bg, v.e_st, v.e_oe, v.e_we, v.e_addr, v.e_din,
               v.e_arv, v.e_ard, v.e_brv, v.e_brd};
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL vec%0d: got %h, expected %h", idx, got, exp);
        end else begin
            $display("vec%0d ag=%b bg=%b st=%b oe=%b we=%b addr=%h arv=%b ard=%h brv=%b brd=%h",
                     idx, a_gnt, b_gnt, a_stall, mem_oe, mem_we, mem_addr,
                     a_rvalid, a_rdata, b_rvalid, b_rdata);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    localparam logic [31:0] Z = 32'h0;
    localparam logic [31:0] DB = 32'hDEADBEEF;
    localparam logic [31:0] BB = 32'hB0B0B0B0;

    initial begin
        // ar aw aa ad | br bw ba bd | dout | ag bg st oe we addr din | arv ard brv brd
        vecs[0]  = mk(F,F,Z,Z,                     F,F,Z,Z,                      Z,            F,F,F,F,F,Z,Z,                     F,Z,F,Z);
        vecs[1]  = mk(T,F,32'h10,32'h11111111,     F,F,Z,Z,                      DB,           T,F,F,T,F,32'h10,32'h11111111,     F,Z,F,Z);
        vecs[2]  = mk(F,F,Z,Z,                     F,F,Z,Z,                      Z,            F,F,F,F,F,Z,Z,                     T,DB,F,Z);
        vecs[3]  = mk(F,F,Z,Z,                     F,F,Z,Z,                      Z,            F,F,F,F,F,Z,Z,                     F,DB,F,Z);
        vecs[4]  = mk(F,F,Z,Z,                     T,T,32'h40,32'h12345678,      32'h77777777, F,T,F,F,T,32'h40,32'h12345678,     F,DB,F,Z);
        vecs[5]  = mk(F,F,Z,Z,                     F,F,Z,Z,                      Z,            F,F,F,F,F,Z,Z,                     F,DB,F,Z);
        vecs[6]  = mk(T,T,32'h20,32'hCAFEF00D,     F,F,Z,Z,                      32'h55555555, T,F,F,F,T,32'h20,32'hCAFEF00D,     F,DB,F,Z);
        vecs[7]  = mk(F,F,Z,Z,                     F,F,Z,Z,                      Z,            F,F,F,F,F,Z,Z,                     F,DB,F,Z);
        vecs[8]  = mk(F,F,Z,Z,                     T,F,32'h44,Z,                 BB,           F,T,F,T,F,32'h44,Z,                F,DB,F,Z);
        vecs[9]  = mk(F,F,Z,Z,                     F,F,Z,Z,                      Z,            F,F,F,F,F,Z,Z,                     F,DB,T,BB);
        // continuous contention: four A grants, one forced B grant
        vecs[10] = mk(T,F,32'h100,Z,               T,F,32'h200,Z,                32'hA1,       T,F,F,T,F,32'h100,Z,               F,DB,F,BB);
        vecs[11] = mk(T,F,32'h100,Z,               T,F,32'h200,Z,                32'hA2,       T,F,F,T,F,32'h100,Z,               T,32'hA1,F,BB);
        vecs[12] = mk(T,F,32'h100,Z,               T,F,32'h200,Z,                32'hA3,       T,F,F,T,F,32'h100,Z,               T,32'hA2,F,BB);
        vecs[13] = mk(T,F,32'h100,Z,               T,F,32'h200,Z,                32'hA4,       T,F,F,T,F,32'h100,Z,               T,32'hA3,F,BB);
        vecs[14] = mk(T,F,32'h100,Z,               T,F,32'h200,Z,                32'hB5,       F,T,T,T,F,32'h200,Z,               T,32'hA4,F,BB);
        vecs[15] = mk(T,F,32'h100,Z,               T,F,32'h200,Z,                32'hA6,       T,F,F,T,F,32'h100,Z,               F,32'hA4,T,32'hB5);
        vecs[16] = mk(T,F,32'h100,Z,               T,F,32'h200,Z,                32'hA7,       T,F,F,T,F,32'h100,Z,               T,32'hA6,F,32'hB5);
        vecs[17] = mk(T,F,32'h100,Z,               T,F,32'h200,Z,                32'hA8,       T,F,F,T,F,32'h100,Z,               T,32'hA7,F,32'hB5);
        vecs[18] = mk(T,F,32'h100,Z,               T,F,32'h200,Z,                32'hA9,       T,F,F,T,F,32'h100,Z,               T,32'hA8,F,32'hB5);
        // B_PRI reached, B abandons its turn
        vecs[19] = mk(T,F,32'h100,Z,               F,F,32'h200,Z,                32'hAA,       T,F,F,T,F,32'h100,Z,               T,32'hA9,F,32'hB5);
        vecs[20] = mk(T,F,32'h100,Z,               T,F,32'h200,Z,                32'hAB,       T,F,F,T,F,32'h100,Z,               T,32'hAA,F,32'hB5);
        vecs[21] = mk(T,F,32'h100,Z,               T,F,32'h200,Z,                32'hAC,       T,F,F,T,F,32'h100,Z,               T,32'hAB,F,32'hB5);
        vecs[22] = mk(T,F,32'h100,Z,               T,F,32'h200,Z,                32'hAD,       T,F,F,T,F,32'h100,Z,               T,32'hAC,F,32'hB5);
        vecs[23] = mk(T,F,32'h100,Z,               T,F,32'h200,Z,                32'hAE,       T,F,F,T,F,32'h100,Z,               T,32'hAD,F,32'hB5);
        vecs[24] = mk(T,F,32'h100,Z,               T,F,32'h200,Z,                32'hBF,       F,T,T,T,F,32'h200,Z,               T,32'hAE,F,32'hB5);
        vecs[25] = mk(F,F,Z,Z,                     F,F,Z,Z,                      Z,            F,F,F,F,F,Z,Z,                     F,32'hAE,T,32'hBF);

        // reset held with requests present: no grants, no SRAM access
        rstb = 1'b0;
        drive(T,F,32'h10,Z, T,F,32'h20,Z, DB);
        @(negedge clk);
        #1;
        chk("rst_a_gnt",    {31'b0, a_gnt},    Z);
        chk("rst_b_gnt",    {31'b0, b_gnt},    Z);
        chk("rst_mem_oe",   {31'b0, mem_oe},   Z);
        chk("rst_a_rvalid", {31'b0, a_rvalid}, Z);
        chk("rst_a_rdata",  a_rdata,           Z);
        @(negedge clk);
        drive(F,F,Z,Z, F,F,Z,Z, Z);
        rstb = 1'b1;

        for (int i = 0; i < 26; i++) apply(i);

        // back-to-back A reads of 0x0, 0x4, 0x8
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i < 3) drive(T,F,32'(4*i),Z, F,F,Z,Z, 32'hD0000000 | 32'(4*i));
            else       drive(F,F,Z,Z, F,F,Z,Z, Z);
            #1;
            if (i < 3) chk($sformatf("b2b_addr%0d", i), mem_addr, 32'(4*i));
            if (i >= 1 && i <= 3) begin
                chk($sformatf("b2b_rvalid%0d", i), {31'b0, a_rvalid}, 32'h1);
                chk($sformatf("b2b_rdata%0d", i), a_rdata, 32'hD0000000 | 32'(4*(i-1)));
            end
            if (i == 4) chk("b2b_rvalid_end", {31'b0, a_rvalid}, Z);
        end

        // reach B_PRI, then reset while an A read is in flight
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            drive(T,F,32'h300,Z, T,F,32'h400,Z, 32'hC0 + 32'(i));
        end
        @(negedge clk);
        drive(T,F,32'h300,Z, F,F,Z,Z, 32'hEEEE0001);
        #1;
        chk("mid_a_gnt", {31'b0, a_gnt}, 32'h1);
        #2;
        rstb = 1'b0;
        #1;
        chk("mid_rst_a_gnt",    {31'b0, a_gnt},    Z);
        chk("mid_rst_mem_oe",   {31'b0, mem_oe},   Z);
        chk("mid_rst_a_rvalid", {31'b0, a_rvalid}, Z);
        chk("mid_rst_a_rdata",  a_rdata,           Z);
        @(negedge clk);
        drive(F,F,Z,Z, F,F,Z,Z, Z);
        rstb = 1'b1;
        #1;
        chk("post_rst_rvalid0", {31'b0, a_rvalid}, Z);
        chk("post_rst_rdata0",  a_rdata,           Z);
        @(negedge clk);
        #1;
        chk("post_rst_rvalid1", {31'b0, a_rvalid}, Z);
        @(negedge clk);
        drive(T,F,32'h500,Z, T,F,32'h600,Z, 32'hF00D0001);
        #1;
        chk("post_rst_a_gnt", {31'b0, a_gnt}, 32'h1);
        chk("post_rst_b_gnt", {31'b0, b_gnt}, Z);
        @(negedge clk);
        drive(F,F,Z,Z, F,F,Z,Z, Z);
        #1;
        chk("post_rst_rvalid2", {31'b0, a_rvalid}, 32'h1);
        chk("post_rst_rdata2",  a_rdata,           32'hF00D0001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter STARVE_LIMIT, default 4, meaning the number of consecutive denied port-B cycles before port B gets forced priority (legal range 1..15).
REQ-002 The block SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 The block SHALL have port rstb  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have port a_req / a_we  input  1 each  pipeline MEM-stage access request / write select.
REQ-005 The block SHALL have port a_addr / a_wdata  input  32 each  pipeline address / write data.
REQ-006 The block SHALL have port a_gnt / a_stall  output  1 each  pipeline grant / pipeline hold request.
REQ-007 The block SHALL have port a_rvalid / a_rdata  output  1 / 32  pipeline read-return strobe / data.
REQ-008 The block SHALL have port b_req / b_we  input  1 each  secondary (loader/debug) request / write select.
REQ-009 The block SHALL have port b_addr / b_wdata  input  32 each  secondary address / write data.
REQ-010 The block SHALL have port b_gnt / b_rvalid / b_rdata  output  1 / 1 / 32  secondary grant / read strobe / data.
REQ-011 The block SHALL have port mem_oe / mem_we  output  1 each  data SRAM output enable / write enable.
REQ-012 The block SHALL have port mem_addr / mem_din  output  32 each  data SRAM address / write data.
REQ-013 The block SHALL have port mem_dout  input  32  data SRAM combinational read data.

Function
REQ-014 Grants SHALL be combinational from current inputs and registered state; at most one of a_gnt, b_gnt high per cycle.
REQ-015 State machine SHALL have two states: A_PRI (port A wins ties) and B_PRI (port B wins ties).
REQ-016 In A_PRI: a_req -> a_gnt; else b_req -> b_gnt; neither -> no grant.
REQ-017 In B_PRI: b_req -> b_gnt; else a_req -> a_gnt.
REQ-018 Starvation counter starve_cnt SHALL increment each cycle b_req=1 and b_gnt=0, saturating at STARVE_LIMIT; SHALL clear on any b_gnt or any cycle with b_req=0.
REQ-019 Transition A_PRI -> B_PRI SHALL occur at the edge where starve_cnt becomes STARVE_LIMIT; B_PRI -> A_PRI at the next edge, whether B was granted or b_req dropped.
REQ-020 Granted port SHALL drive mem_addr, mem_din, mem_we=req_we, mem_oe=~req_we; with no grant mem_oe=mem_we=0, mem_addr=mem_din=0.
REQ-021 Read latency SHALL be 1 cycle: on a granted read, mem_dout captured at the edge; owning port's rvalid high for exactly the following cycle.
REQ-022 a_rdata / b_rdata SHALL hold the last captured value until the next read by that port; writes SHALL NOT assert rvalid or alter rdata.
REQ-023 a_stall SHALL equal a_req & ~a_gnt (combinational), so the pipeline holds its MEM-stage registers.
REQ-024 Back-to-back grants to either port SHALL be supported every cycle with no bubble.
REQ-025 Changes of req/addr without a grant SHALL have no effect on SRAM or state other than starve_cnt.

Reset
REQ-026 rstb=0 SHALL immediately force state A_PRI, starve_cnt=0, a_rvalid=b_rvalid=0, a_rdata=b_rdata=0, independent of clk.
REQ-027 Reset during an access SHALL drop the pending rvalid; no return for that access after rstb release.
REQ-028 While rstb=0, grants SHALL be forced 0 and mem_oe=mem_we=0.
REQ-029 First edge after rstb release SHALL operate normally from A_PRI.

Verification
REQ-030 A read alone: a_req=1, a_we=0, a_addr=0x10, mem_dout=0xDEADBEEF -> a_gnt=1, mem_oe=1 same cycle; a_rvalid=1, a_rdata=0xDEADBEEF next cycle only.
REQ-031 B write alone: b_req=1, b_we=1, b_addr=0x40, b_wdata=0x12345678 -> b_gnt=1, mem_we=1, mem_addr=0x40, mem_din=0x12345678; b_rvalid stays 0.
REQ-032 Contention, STARVE_LIMIT=4, a_req=b_req=1 continuous -> cycles 1-4 a_gnt=1, a_stall=0; cycle 5 b_gnt=1, a_stall=1; cycle 6 a_gnt=1; pattern repeats every 5 cycles.
REQ-033 Forced-priority abandon: reach B_PRI, then drop b_req -> a_gnt=1 that cycle, state A_PRI and starve_cnt=0 next cycle.
REQ-034 Reset mid-read: A read granted, rstb=0 before next edge -> a_rvalid=0, a_rdata=0; after release with a_req=0, no rvalid appears.
REQ-035 Back-to-back: A reads 0x0, 0x4, 0x8 on three consecutive cycles -> a_rvalid high three consecutive cycles with matching data in order.
